// File: rtl/burst_bram_responder_pkg.sv
// rtl/burst_bram_responder_pkg.sv - shared bus widths and command encodings
//
// Purpose: constants shared by the burst responder and its callers.
// Ports:   none (package).

package burst_bram_responder_pkg;

    localparam int DATA_BUS = 32;
    localparam int ADDR_BUS = 16;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/bram_sp.sv
// rtl/bram_sp.sv - single-port synchronous block RAM with registered read data
//
// Purpose: inferred single-port RAM; one access per cycle, write or read.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (read data register only)
//   en     in   access enable
//   we     in   write enable (qualified by en)
//   addr   in   word address
//   wdata  in   write word
//   rdata  out  read word, valid the cycle after a read access, held otherwise

module bram_sp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds its value whenever no read access is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_bram_responder.sv
// rtl/burst_bram_responder.sv - block-burst memory responder for the data cache
//
// Purpose: serves whole-block read bursts (cache populate) and write bursts
//          (dirty write-back) from an internal single-port RAM.
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   mem_enable      in   request present
//   mem_rw          in   0 = read, 1 = write
//   mem_addr        in   word address of burst; low BURST_WIDTH bits ignored
//   mem_write       in   current write word from initiator
//   mem_read        out  read word
//   mem_read_valid  out  mem_read holds a burst word
//   mem_write_req   out  one-cycle pulse: mem_write consumed, present the next
//   mem_last        out  final word of burst

module burst_bram_responder
    import burst_bram_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_BUS,
    parameter int ADDR_WIDTH      = ADDR_BUS,
    parameter int BURST_WIDTH     = 5,
    parameter int MEM_WORDS_WIDTH = 12,
    parameter     INIT_FILE       = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_write,
    output logic [DATA_WIDTH-1:0] mem_read,
    output logic                  mem_read_valid,
    output logic                  mem_write_req,
    output logic                  mem_last
);

    localparam int BASE_WIDTH = MEM_WORDS_WIDTH - BURST_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_CAP,
        WR_WAIT,
        WR_END
    } state_t;

    state_t                       state;
    logic [BASE_WIDTH-1:0]        base_hi;
    logic [BURST_WIDTH-1:0]       cnt;
    logic                         cnt_final;
    logic                         ram_en;
    logic                         ram_we;
    logic [MEM_WORDS_WIDTH-1:0]   ram_addr;

    // Address bits outside the RAM's block index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:MEM_WORDS_WIDTH],
                                mem_addr[BURST_WIDTH-1:0]};

    // Bases are block aligned, so base + k is a concatenation, not an add.
    assign ram_addr  = {base_hi, cnt};
    assign cnt_final = &cnt;

    // The RAM is accessed on the very edge the FSM acts on, so a read issued
    // in RD lands in mem_read together with mem_read_valid. The extra RD
    // cycle spent with mem_last high does not touch the RAM.
    assign ram_en = mem_enable &&
                    (((state == RD) && !mem_last) || (state == WR_CAP));
    assign ram_we = (state == WR_CAP);

    bram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_WORDS_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_write),
        .rdata (mem_read)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_hi        <= '0;
            cnt            <= '0;
            mem_read_valid <= FALSE;
            mem_write_req  <= FALSE;
            mem_last       <= FALSE;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        base_hi <= mem_addr[MEM_WORDS_WIDTH-1:BURST_WIDTH];
                        cnt     <= '0;
                        state   <= (mem_rw == MEM_WRITE) ? WR_CAP : RD;
                    end
                end

                // mem_last high means word N-1 went out on the previous edge.
                RD: begin
                    if (!mem_enable || mem_last) begin
                        mem_read_valid <= FALSE;
                        mem_last       <= FALSE;
                        state          <= IDLE;
                    end else begin
                        mem_read_valid <= TRUE;
                        mem_last       <= cnt_final;
                        cnt            <= cnt + 1'b1;
                    end
                end

                WR_CAP: begin
                    if (!mem_enable) begin
                        mem_write_req <= FALSE;
                        mem_last      <= FALSE;
                        state         <= IDLE;
                    end else if (cnt_final) begin
                        mem_last <= TRUE;
                        state    <= WR_END;
                    end else begin
                        mem_write_req <= TRUE;
                        cnt           <= cnt + 1'b1;
                        state         <= WR_WAIT;
                    end
                end

                // Gives the initiator one edge to advance mem_write.
                WR_WAIT: begin
                    mem_write_req <= FALSE;
                    state         <= mem_enable ? WR_CAP : IDLE;
                end

                WR_END: begin
                    mem_last <= FALSE;
                    state    <= IDLE;
                end

                default: begin
                    mem_read_valid <= FALSE;
                    mem_write_req  <= FALSE;
                    mem_last       <= FALSE;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
